// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction buffer: circular FIFO of {inst, pc, npc}.
// Squash flushes it synchronously; the head entry feeds decode directly.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module inst_buffer #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic                     if_valid,
  input  logic [31:0]              if_inst,
  input  logic [`XLEN-1:0]         if_pc,
  input  logic [`XLEN-1:0]         if_npc,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [31:0]              id_inst,
  output logic [`XLEN-1:0]         id_pc,
  output logic [`XLEN-1:0]         id_npc,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]      inst;
    logic [`XLEN-1:0] pc;
    logic [`XLEN-1:0] npc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          enq;
  logic          deq;

  assign if_ready    = count < CW'(DEPTH);
  assign almost_full = count >= CW'(AF_THRESH);
  assign id_valid    = count != '0;

  assign enq = if_valid & if_ready & ~squash;
  assign deq = id_valid & id_ready & ~squash;

  always_comb begin
    id_inst = `NOP;
    id_pc   = '0;
    id_npc  = '0;
    if (id_valid) begin
      id_inst = mem[head].inst;
      id_pc   = mem[head].pc;
      id_npc  = mem[head].npc;
    end
  end

  // Payload needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem[tail] <= '{inst: if_inst, pc: if_pc, npc: if_npc};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + AW'(1);
      if (deq) head <= head + AW'(1);
      unique case (1'b1)
        enq & ~deq: count <= count + CW'(1);
        deq & ~enq: count <= count - CW'(1);
        default:    count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: reset, fill/drain, streaming,
// squash, full-with-dequeue and asynchronous reset.
module tb_inst_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        squash;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_npc;
  logic        id_ready;
  logic [3:0]  count;
  logic        almost_full;

  int total;
  int passed;

  inst_buffer #(.DEPTH(8), .AF_THRESH(6)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_npc(if_npc), .if_ready(if_ready), .id_valid(id_valid),
    .id_inst(id_inst), .id_pc(id_pc), .id_npc(id_npc),
    .id_ready(id_ready), .count(count), .almost_full(almost_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    if_npc   = pc + 32'd4;
    if_inst  = 32'h0000_0093 ^ {pc[11:0], 20'h0};
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h0000_0093 ^ {pc[11:0], 20'h0};
  endfunction

  initial begin
    total    = 0;
    passed   = 0;
    reset    = 1'b0;
    squash   = 1'b0;
    if_valid = 1'b0;
    if_inst  = '0;
    if_pc    = '0;
    if_npc   = '0;
    id_ready = 1'b0;
    #12;
    chk("rst_if_ready", if_ready, 1);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_npc", id_npc, 0);
    chk("rst_count", count, 0);
    chk("rst_af", almost_full, 0);
    tick();
    reset = 1'b1;

    // single enqueue then dequeue
    if_valid = 1'b1;
    if_inst  = 32'h00A0_0093;
    if_pc    = 32'h100;
    if_npc   = 32'h104;
    tick();
    if_valid = 1'b0;
    chk("t1_valid", id_valid, 1);
    chk("t1_inst", id_inst, 32'h00A0_0093);
    chk("t1_pc", id_pc, 32'h100);
    chk("t1_npc", id_npc, 32'h104);
    chk("t1_count", count, 1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("t1_empty_valid", id_valid, 0);
    chk("t1_empty_inst", id_inst, NOP);
    chk("t1_empty_pc", id_pc, 0);
    chk("t1_empty_count", count, 0);

    // fill to full, reject 9th, drain in order
    for (int i = 0; i < 8; i++) begin
      present(32'(i * 4));
      chk("fill_if_ready", if_ready, 1);
      chk("fill_af", almost_full, (i >= 6) ? 1 : 0);
      tick();
    end
    chk("full_count", count, 8);
    chk("full_if_ready", if_ready, 0);
    chk("full_af", almost_full, 1);
    present(32'h20);
    tick();
    if_valid = 1'b0;
    chk("ninth_count", count, 8);
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_pc", id_pc, 32'(i * 4));
      chk("drain_inst", id_inst, inst_of(32'(i * 4)));
      tick();
    end
    id_ready = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_valid", id_valid, 0);

    // steady stream, 20 cycles
    id_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      present(32'h1000 + 32'(k * 4));
      if (k > 0) begin
        chk("stream_pc", id_pc, 32'h1000 + 32'((k - 1) * 4));
        chk("stream_count", count, 1);
      end
      tick();
    end
    if_valid = 1'b0;
    chk("stream_last_pc", id_pc, 32'h1000 + 32'(19 * 4));
    tick();
    id_ready = 1'b0;
    chk("stream_end_count", count, 0);

    // squash with five entries
    for (int i = 0; i < 5; i++) begin
      present(32'h300 + 32'(i * 4));
      tick();
    end
    chk("sq_pre_count", count, 5);
    present(32'h3FC);
    id_ready = 1'b1;
    squash   = 1'b1;
    tick();
    squash   = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b0;
    chk("sq_count", count, 0);
    chk("sq_valid", id_valid, 0);
    chk("sq_if_ready", if_ready, 1);
    chk("sq_inst", id_inst, NOP);
    present(32'h200);
    tick();
    if_valid = 1'b0;
    chk("sq_new_valid", id_valid, 1);
    chk("sq_new_pc", id_pc, 32'h200);
    chk("sq_new_count", count, 1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("sq_after_count", count, 0);

    // full with simultaneous enqueue and dequeue
    for (int i = 0; i < 8; i++) begin
      present(32'h400 + 32'(i * 4));
      tick();
    end
    present(32'h4FC);
    id_ready = 1'b1;
    chk("fd_if_ready_pre", if_ready, 0);
    tick();
    if_valid = 1'b0;
    id_ready = 1'b0;
    chk("fd_count", count, 7);
    chk("fd_if_ready", if_ready, 1);
    id_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("fd_drain_pc", id_pc, 32'h400 + 32'(i * 4));
      tick();
    end
    id_ready = 1'b0;
    chk("fd_end_count", count, 0);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) begin
      present(32'h500 + 32'(i * 4));
      tick();
    end
    if_valid = 1'b0;
    chk("ar_pre_count", count, 4);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", id_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_if_ready", if_ready, 1);
    chk("ar_inst", id_inst, NOP);
    tick();
    reset = 1'b1;
    present(32'h600);
    tick();
    if_valid = 1'b0;
    chk("ar_new_valid", id_valid, 1);
    chk("ar_new_pc", id_pc, 32'h600);
    chk("ar_new_npc", id_npc, 32'h604);
    chk("ar_new_count", count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
